// File: rtl/uart_pkg.sv
// Shared types and default sizes for the buffered UART controller.
package uart_pkg;

    typedef enum logic {
        DROP_NEW      = 1'b0,
        OVERWRITE_OLD = 1'b1
    } overflow_mode_t;

    localparam int DEFAULT_WIDTH     = 8;
    localparam int DEFAULT_DEPTH_LOG = 3;
    localparam int DEFAULT_LOST_W    = 8;

endpackage

// File: rtl/uart_fifo.sv
// Circular word FIFO with extra-MSB pointers; when full a push either drops
// the new word or evicts the oldest one, depending on MODE.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int             WIDTH     = DEFAULT_WIDTH,
    parameter int             DEPTH_LOG = DEFAULT_DEPTH_LOG,
    parameter overflow_mode_t MODE      = DROP_NEW
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 push,
    input  logic [WIDTH-1:0]     din,
    input  logic                 pop,
    output logic [WIDTH-1:0]     head,
    output logic [DEPTH_LOG:0]   level,
    output logic                 full,
    output logic                 empty
);

    localparam int DEPTH = 1 << DEPTH_LOG;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH_LOG:0] wr_ptr_reg;
    logic [DEPTH_LOG:0] rd_ptr_reg;
    logic               do_pop;
    logic               do_push;
    logic               evict;

    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[DEPTH_LOG] != rd_ptr_reg[DEPTH_LOG]) &&
                   (wr_ptr_reg[DEPTH_LOG-1:0] == rd_ptr_reg[DEPTH_LOG-1:0]);
    assign level = wr_ptr_reg - rd_ptr_reg;
    assign head  = mem[rd_ptr_reg[DEPTH_LOG-1:0]];

    // A pop in the same cycle frees a slot, so a push on a full FIFO then
    // succeeds without eviction.
    assign do_pop  = pop && !empty;
    assign evict   = (MODE == OVERWRITE_OLD) && push && full && !do_pop;
    assign do_push = push && (!full || do_pop || evict);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop || evict) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr_reg[DEPTH_LOG-1:0]] <= din;
        end
    end

endmodule

// File: rtl/uart_buffered_controller.sv
// Buffered UART controller: RX/TX FIFOs between the bit-level UART and the
// core's request/acknowledge byte ports, with lost-word counting and flush.
module uart_buffered_controller
    import uart_pkg::*;
#(
    parameter int WIDTH        = DEFAULT_WIDTH,
    parameter int RX_DEPTH_LOG = DEFAULT_DEPTH_LOG,
    parameter int TX_DEPTH_LOG = DEFAULT_DEPTH_LOG,
    parameter int RX_OVERWRITE = 0,
    parameter int LOST_W       = DEFAULT_LOST_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    output logic                    recv_reset,
    input  logic [WIDTH-1:0]        recv_data,
    input  logic                    recv_ok,
    output logic                    trans_reset,
    output logic [WIDTH-1:0]        trans_data,
    output logic                    trans_start,
    input  logic                    trans_busy,
    input  logic [WIDTH-1:0]        uart_in_data,
    input  logic                    uart_in_valid,
    output logic                    uart_in_ready,
    input  logic                    uart_out_valid,
    output logic [WIDTH-1:0]        uart_out_data,
    output logic                    uart_out_ready,
    output logic [RX_DEPTH_LOG:0]   rx_level,
    output logic [TX_DEPTH_LOG:0]   tx_level,
    output logic [LOST_W-1:0]       lost
);

    localparam overflow_mode_t    RX_MODE  = (RX_OVERWRITE != 0) ? OVERWRITE_OLD : DROP_NEW;
    localparam logic [LOST_W-1:0] LOST_MAX = {LOST_W{1'b1}};

    logic [WIDTH-1:0] rx_head;
    logic [WIDTH-1:0] tx_head;
    logic             rx_full;
    logic             rx_empty;
    logic             tx_full;
    logic             tx_empty;
    logic             rx_push;
    logic             rx_pop;
    logic             rx_lost;
    logic             tx_push;
    logic             tx_pop;
    logic             reset_hold_reg;

    // Requests are ignored while their acknowledge is high, which limits the
    // core ports to one transfer per two cycles.
    assign rx_push = recv_ok && !flush;
    assign rx_pop  = uart_out_valid && !uart_out_ready && !rx_empty && !flush;
    assign rx_lost = rx_push && rx_full && !rx_pop;
    assign tx_push = uart_in_valid && !uart_in_ready && !tx_full && !flush;
    assign tx_pop  = !tx_empty && !trans_busy && !trans_start && !flush;

    assign recv_reset  = reset_hold_reg;
    assign trans_reset = reset_hold_reg;

    uart_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH_LOG (RX_DEPTH_LOG),
        .MODE      (RX_MODE)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (rx_push),
        .din   (recv_data),
        .pop   (rx_pop),
        .head  (rx_head),
        .level (rx_level),
        .full  (rx_full),
        .empty (rx_empty)
    );

    uart_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH_LOG (TX_DEPTH_LOG),
        .MODE      (DROP_NEW)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .push  (tx_push),
        .din   (uart_in_data),
        .pop   (tx_pop),
        .head  (tx_head),
        .level (tx_level),
        .full  (tx_full),
        .empty (tx_empty)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reset_hold_reg <= 1'b1;
            uart_out_ready <= 1'b0;
            uart_out_data  <= '0;
            uart_in_ready  <= 1'b0;
            trans_start    <= 1'b0;
            trans_data     <= '0;
            lost           <= '0;
        end else begin
            reset_hold_reg <= 1'b0;
            uart_out_ready <= rx_pop;
            uart_in_ready  <= tx_push;
            trans_start    <= tx_pop;
            if (rx_pop) begin
                uart_out_data <= rx_head;
            end
            if (tx_pop) begin
                trans_data <= tx_head;
            end
            if (flush) begin
                lost <= '0;
            end else if (rx_lost && lost != LOST_MAX) begin
                lost <= lost + 1'b1;
            end
        end
    end

endmodule

// File: doc/uart_buffered_controller.md
# uart_buffered_controller

Buffered UART controller between the bit-level receiver/transmitter and the core's byte-stream request ports. Holds received words in an RX FIFO and outgoing words in a TX FIFO, both parametrised in data width and depth. Adds a selectable RX overflow policy, a saturating lost-word counter, occupancy outputs and a synchronous flush on top of the fixed-width, drop-only controller.

## Interface
- WIDTH, 8: data word width for both directions
- RX_DEPTH_LOG, 3: RX FIFO holds 2**RX_DEPTH_LOG words
- TX_DEPTH_LOG, 3: TX FIFO holds 2**TX_DEPTH_LOG words
- RX_OVERWRITE, 0: 0 = drop newest word when full; 1 = overwrite oldest word
- LOST_W, 8: lost-counter width

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous clear of both FIFOs and lost counter
- recv_reset  out  1  reset to receiver
- recv_data  in  WIDTH  received word
- recv_ok  in  1  one-cycle strobe, recv_data valid
- trans_reset  out  1  reset to transmitter
- trans_data  out  WIDTH  word to transmit
- trans_start  out  1  one-cycle strobe, start transmitting trans_data
- trans_busy  in  1  transmitter shifting
- uart_in_data  in  WIDTH  word from core to send
- uart_in_valid  in  1  core write request
- uart_in_ready  out  1  one-cycle acknowledge, word accepted
- uart_out_valid  in  1  core read request
- uart_out_data  out  WIDTH  word to core, valid while uart_out_ready=1
- uart_out_ready  out  1  one-cycle acknowledge, uart_out_data valid
- rx_level  out  RX_DEPTH_LOG+1  RX occupancy
- tx_level  out  TX_DEPTH_LOG+1  TX occupancy
- lost  out  LOST_W  saturating count of lost RX words

## Operation
- Reset: all outputs 0 except recv_reset = trans_reset = 1; FIFOs empty. recv_reset/trans_reset assert asynchronously with reset and deassert at the first clk rising edge with reset low.
- RX push: recv_ok=1 pushes recv_data. Full and RX_OVERWRITE=0: word discarded, lost+1. Full and RX_OVERWRITE=1: oldest word discarded, new word pushed, lost+1. lost saturates at 2**LOST_W-1.
- RX pop: uart_out_valid=1, uart_out_ready=0, FIFO non-empty -> next cycle uart_out_ready=1 with head word on uart_out_data, word popped. Request ignored while uart_out_ready=1, so at most one pop per two cycles. Empty -> no acknowledge, request held.
- TX push: uart_in_valid=1, uart_in_ready=0, TX not full -> word pushed, uart_in_ready=1 next cycle. Full -> no acknowledge, core must hold request. Never drops.
- TX drain: TX non-empty, trans_busy=0, trans_start=0 -> pop head to trans_data, trans_start=1 for one cycle. No new start in the cycle after a start (transmitter raises trans_busy within one cycle). trans_data holds until next start.
- Simultaneous RX push and pop on full FIFO: pop first, push succeeds, no loss, level unchanged. On empty FIFO: pop not acknowledged that cycle.
- Simultaneous TX push and drain: both occur; tx_level unchanged.
- flush: both FIFOs emptied, lost cleared, pending acknowledges cancelled; recv_ok in the same cycle is discarded (not counted).

## Timing
- RX latency: recv_ok at edge N -> word poppable by request sampled at N+1 -> uart_out_ready at N+2.
- TX latency: push at edge N -> trans_start at N+1 earliest, if idle.
- All outputs registered; no combinational path input->output.
- Levels reflect state after the current edge; rx_level range 0..2**RX_DEPTH_LOG.
- Pointers are RX_DEPTH_LOG+1 / TX_DEPTH_LOG+1 bits, wrap modulo twice the depth; full = MSBs differ, low bits equal.

## Structure
- Package uart_pkg: overflow-mode enum (DROP_NEW, OVERWRITE_OLD), default width constants.
- Sub-module uart_fifo (WIDTH, DEPTH_LOG, overwrite enable): push/pop/level/full/empty; instantiated for RX (overwrite per parameter) and TX (overwrite off).
- Top holds handshake registers, lost counter and reset mirroring; no explicit state machine beyond acknowledge/start flags.

## Test plan
- Reset held 5 cycles -> recv_reset=trans_reset=1, other outputs 0; one cycle after release both 0.
- RX_DEPTH_LOG=2, RX_OVERWRITE=0: push 4x 8'hB3 then 3x 8'h4C -> lost=3; reads return B3,B3,B3,B3, then no ack; rx_level 4->0.
- RX_OVERWRITE=1, same stimulus -> lost=3; reads return B3,4C,4C,4C.
- TX: write 8'h5A, 8'hA5 with trans_busy=0 -> uart_in_ready pulses; trans_start with trans_data=5A; hold trans_busy=1 10 cycles, then 0 -> trans_start with A5.
- TX full (TX_DEPTH_LOG=2, trans_busy=1): 5th write gets no uart_in_ready until one drain; no word lost.
- Simultaneous: full RX, recv_ok=1 in the cycle a pop is acknowledged -> lost unchanged, rx_level stays 4; flush with recv_ok=1 -> levels 0, lost 0.
